imem_boot_loader: RTL



---
 rtl/imem_boot_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Byte-serial loader that writes a length-prefixed, big-endian instruction image
// into the MIPS instruction memory and holds the core in reset until it is done.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
//
// Byte handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
// rx_ready is a registered output, so it never depends combinationally on rx_valid.
module imem_boot_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        accept;
  logic [15:0] len_rx;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign len_rx    = {len_hi, rx_data};
  assign last_word = (word_idx == len - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LEN_HI;
      len_hi       <= 8'h00;
      len          <= 16'h0000;
      word_idx     <= 16'h0000;
      byte_idx     <= 2'd0;
      asm_q        <= 24'h000000;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0000_0000;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 8'h00;
`endif
    end else begin
      imem_we  <= 1'b0;
      rx_ready <= (state != S_DONE);
      // Released one edge after load_done, so the final write lands first.
      core_reset <= !(load_done && !load_err);

      case (state)
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            csum   <= 8'h00;
`endif
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len      <= len_rx;
            word_idx <= 16'h0000;
            byte_idx <= 2'd0;
            if (len_rx > DEPTH_W) begin
              load_err <= 1'b1;
            end
            if (len_rx == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
              state     <= S_CSUM;
`else
              state     <= S_DONE;
              rx_ready  <= 1'b0;
              load_done <= 1'b1;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Words past the memory end are consumed but never written.
              if (word_idx < DEPTH_W) begin
                imem_we      <= 1'b1;
                imem_addr    <= ADDR_W'({word_idx, 2'b00});
                imem_wdata   <= {asm_q, rx_data};
                words_loaded <= words_loaded + 16'd1;
              end
              word_idx <= word_idx + 16'd1;
              if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state     <= S_CSUM;
`else
                state     <= S_DONE;
                rx_ready  <= 1'b0;
                load_done <= 1'b1;
`endif
              end
            end else begin
              asm_q <= {asm_q[15:0], rx_data};
            end
          end
        end

        S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) begin
            if (rx_data != csum) begin
              load_err <= 1'b1;
            end
            state     <= S_DONE;
            rx_ready  <= 1'b0;
            load_done <= 1'b1;
          end
`else
          state    <= S_DONE;
          rx_ready <= 1'b0;
`endif
        end

        S_DONE: begin
          rx_ready <= 1'b0;
        end

        default: begin
          state    <= S_DONE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
